// File: rtl/seg_scan_driver.sv
// Time-multiplexed two-digit 7-segment scan driver with per-frame shadow capture.
// Optional yellow-light blink is compiled in with `define SEG_SCAN_BLINK_EN.
module seg_scan_driver #(
  parameter int SCAN_DIV   = 50000,
  parameter int GAP_CYCLES = 16,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seg_tens,
  input  logic [6:0] seg_units,
  input  logic       yellow_light,
  output logic [6:0] seg_out,
  output logic [1:0] digit_an
);

  localparam int MAX_SG  = (SCAN_DIV > GAP_CYCLES) ? SCAN_DIV : GAP_CYCLES;
  localparam int MAX_ALL = (MAX_SG > BLINK_DIV) ? MAX_SG : BLINK_DIV;
  localparam int CNT_W   = $clog2(MAX_ALL);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  localparam logic [1:0] SHOW_T = 2'd0;
  localparam logic [1:0] GAP_T  = 2'd1;
  localparam logic [1:0] SHOW_U = 2'd2;
  localparam logic [1:0] GAP_U  = 2'd3;

  localparam logic [6:0] BLANK = 7'h7F;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       sh_tens_q, sh_tens_d;
  logic [6:0]       sh_units_q, sh_units_d;
  logic             capture;
  logic             blink_on;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    capture = 1'b0;
    if (!en) begin
      // Park at the terminal gap count so re-enabling enters SHOW_T immediately.
      state_d = GAP_U;
      cnt_d   = GAP_LAST;
    end else begin
      case (state_q)
        SHOW_T: if (cnt_q == SCAN_LAST) begin state_d = GAP_T;  cnt_d = '0; end
        GAP_T:  if (cnt_q == GAP_LAST)  begin state_d = SHOW_U; cnt_d = '0; end
        SHOW_U: if (cnt_q == SCAN_LAST) begin state_d = GAP_U;  cnt_d = '0; end
        GAP_U:  if (cnt_q == GAP_LAST)  begin state_d = SHOW_T; cnt_d = '0; capture = 1'b1; end
        default: begin state_d = GAP_U; cnt_d = GAP_LAST; end
      endcase
    end
    sh_tens_d  = capture ? seg_tens  : sh_tens_q;
    sh_units_d = capture ? seg_units : sh_units_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GAP_U;
      cnt_q      <= GAP_LAST;
      sh_tens_q  <= BLANK;
      sh_units_q <= BLANK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_tens_q  <= sh_tens_d;
      sh_units_q <= sh_units_d;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blk_phase_q, blk_phase_d;

  // A fresh yellow period always starts with a full on-phase.
  always_comb begin
    blk_cnt_d   = '0;
    blk_phase_d = 1'b1;
    if (yellow_light) begin
      if (blk_cnt_q == BLINK_LAST) begin
        blk_cnt_d   = '0;
        blk_phase_d = ~blk_phase_q;
      end else begin
        blk_cnt_d   = blk_cnt_q + BLK_W'(1);
        blk_phase_d = blk_phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_cnt_q   <= '0;
      blk_phase_q <= 1'b1;
    end else begin
      blk_cnt_q   <= blk_cnt_d;
      blk_phase_q <= blk_phase_d;
    end
  end

  assign blink_on = blk_phase_q;
`else
  logic unused_yellow;
  assign unused_yellow = yellow_light;
  assign blink_on      = 1'b1;
`endif

  always_comb begin
    seg_out  = BLANK;
    digit_an = 2'b11;
    if (blink_on) begin
      case (state_q)
        SHOW_T: begin digit_an = 2'b01; seg_out = sh_tens_q;  end
        SHOW_U: begin digit_an = 2'b10; seg_out = sh_units_q; end
        default: begin digit_an = 2'b11; seg_out = BLANK; end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed vector table, blink sequence, randomized run against a frame-position model.
module tb_seg_scan_driver;
  localparam int S = 4;
  localparam int G = 2;
  localparam int B = 8;
  localparam int F = 2 * (S + G);

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       yl = 1'b0;
  logic [6:0] tens = 7'h40;
  logic [6:0] units = 7'h79;
  logic [6:0] seg_out;
  logic [1:0] digit_an;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(S), .GAP_CYCLES(G), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .en(en), .seg_tens(tens), .seg_units(units),
    .yellow_light(yl), .seg_out(seg_out), .digit_an(digit_an)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Model: position within a frame, captured digits, and length of the current yellow run.
  int         m_pos = F - 1;
  logic [6:0] m_t = 7'h7F;
  logic [6:0] m_u = 7'h7F;
  int         m_yrun = 0;

  task automatic model_step();
    if (rst) begin
      m_pos = F - 1; m_t = 7'h7F; m_u = 7'h7F; m_yrun = 0;
    end else begin
      if (!en) m_pos = F - 1;
      else begin
        m_pos = (m_pos + 1) % F;
        if (m_pos == 0) begin m_t = tens; m_u = units; end
      end
      m_yrun = yl ? m_yrun + 1 : 0;
    end
  endtask

  task automatic model_exp(output logic [1:0] an, output logic [6:0] seg);
    bit on;
`ifdef SEG_SCAN_BLINK_EN
    on = ((m_yrun / B) % 2) == 0;
`else
    on = 1'b1;
`endif
    an = 2'b11; seg = 7'h7F;
    if (on && m_pos < S) begin an = 2'b01; seg = m_t; end
    else if (on && m_pos >= S + G && m_pos < 2 * S + G) begin an = 2'b10; seg = m_u; end
  endtask

  task automatic check(input string name, input logic [1:0] ean, input logic [6:0] eseg);
    n_chk++;
    if (digit_an === ean && seg_out === eseg) n_pass++;
    else $display("FAIL %s: digit_an=%b seg_out=%h, expected %b/%h", name, digit_an, seg_out, ean, eseg);
  endtask

  task automatic check_model(input string name);
    logic [1:0] ean;
    logic [6:0] eseg;
    model_exp(ean, eseg);
    check(name, ean, eseg);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [6:0] t;
    logic [6:0] u;
    logic [1:0] an;
    logic [6:0] seg;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic e, input logic [6:0] t, input logic [6:0] u,
                     input logic [1:0] an, input logic [6:0] seg, input int n);
    vec_t v;
    v.r = r; v.e = e; v.t = t; v.u = u; v.an = an; v.seg = seg;
    for (int i = 0; i < n; i++) vt.push_back(v);
  endtask

  initial begin
    // Reset, then plain frame
    add(1, 1, 7'h40, 7'h79, 2'b11, 7'h7F, 1);
    add(0, 1, 7'h40, 7'h79, 2'b01, 7'h40, 4);
    add(0, 1, 7'h40, 7'h79, 2'b11, 7'h7F, 2);
    add(0, 1, 7'h40, 7'h79, 2'b10, 7'h79, 1);
    // Tens changes mid SHOW_U: not visible until the next frame
    add(0, 1, 7'h24, 7'h79, 2'b10, 7'h79, 3);
    add(0, 1, 7'h24, 7'h79, 2'b11, 7'h7F, 2);
    add(0, 1, 7'h24, 7'h79, 2'b01, 7'h24, 2);
    // Enable dropped on SHOW_T cycle 2, then restored with new units
    add(0, 0, 7'h24, 7'h79, 2'b11, 7'h7F, 2);
    add(0, 1, 7'h24, 7'h06, 2'b01, 7'h24, 4);
    add(0, 1, 7'h24, 7'h06, 2'b11, 7'h7F, 2);
    add(0, 1, 7'h24, 7'h06, 2'b10, 7'h06, 1);
    // Reset mid SHOW_U, frame restarts from scratch
    add(1, 1, 7'h40, 7'h79, 2'b11, 7'h7F, 1);
    add(0, 1, 7'h40, 7'h79, 2'b01, 7'h40, 4);
    add(0, 1, 7'h40, 7'h79, 2'b11, 7'h7F, 2);
    add(0, 1, 7'h40, 7'h79, 2'b10, 7'h79, 4);
    add(0, 1, 7'h40, 7'h79, 2'b11, 7'h7F, 1);

    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].r; en = vt[i].e; tens = vt[i].t; units = vt[i].u;
      tick();
      check($sformatf("vec%0d", i), vt[i].an, vt[i].seg);
    end

    // Yellow held for 32 cycles, then released
    yl = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      check_model($sformatf("blink%0d", i));
    end
    yl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_model($sformatf("blink_exit%0d", i));
    end

    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      en  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) tens = 7'($urandom);
      if ($urandom_range(0, 7) == 0) units = 7'($urandom);
      if ($urandom_range(0, 39) == 0) yl = ~yl;
      tick();
      check_model("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
